// File: rtl/write_back_stage_pkg.sv
// Shared encodings for the write-back stage: source select, load funct3 codes
// and FSM state.
package write_back_stage_pkg;

    typedef enum logic [1:0] {
        REG_WB_ALU_OUT = 2'd0,
        REG_WB_IMM_DAT = 2'd1,
        REG_WB_MEM_DAT = 2'd2,
        REG_WB_PC_NEXT = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } state_e;

endpackage

// File: rtl/write_back_stage_load_align.sv
// Combinational load data alignment: shifts the raw memory word down by the
// byte offset and sign/zero-extends to XLEN according to funct3.
module load_align
    import write_back_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] raw,
    input  logic [2:0]      funct3,
    input  logic [2:0]      addr_lo,
    output logic [XLEN-1:0] data
);

    localparam int OFF_W = (XLEN == 64) ? 3 : 2;

    logic [OFF_W-1:0]   byte_off;
    logic               word_off;
    logic [7:0]         byte_sh;
    logic [15:0]        half_sh;
    logic [31:0]        word_sh;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] word_s;

    always_comb begin
        byte_off = addr_lo[OFF_W-1:0];
        word_off = (XLEN == 64) ? addr_lo[2] : 1'b0;
        byte_sh  = 8'(raw >> {byte_off, 3'b000});
        half_sh  = 16'(raw >> {byte_off[OFF_W-1:1], 4'b0000});
        word_sh  = 32'(raw >> {word_off, 5'b00000});
        byte_s   = byte_sh;
        half_s   = half_sh;
        word_s   = word_sh;

        data = XLEN'(word_s);
        case (funct3)
            F3_LB:  data = XLEN'(byte_s);
            F3_LBU: data = XLEN'(byte_sh);
            F3_LH:  data = XLEN'(half_s);
            F3_LHU: data = XLEN'(half_sh);
            F3_LW:  data = XLEN'(word_s);
            // On RV32 the remaining codes fall back to LW; on RV64 they are LWU/LD.
            F3_LWU: data = (XLEN == 64) ? XLEN'(word_sh) : XLEN'(word_s);
            default: data = (XLEN == 64) ? raw : XLEN'(word_s);
        endcase
    end

endmodule

// File: rtl/write_back_stage.sv
// Registered write-back stage: selects ALU/IMM/PC+4 or aligned load data and
// drives the register-file write port, with load timeout and flush handling.
module write_back_stage
    import write_back_stage_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            wb_sel,
    input  logic [XLEN-1:0]       alu_result,
    input  logic [XLEN-1:0]       immediate,
    input  logic [XLEN-1:0]       pc_next,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  rd_we,
    input  logic [2:0]            load_funct3,
    input  logic [2:0]            load_addr_lo,
    input  logic                  flush,
    input  logic                  mem_rsp_valid,
    input  logic [XLEN-1:0]       mem_rsp_data,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  load_fault,
    output logic                  busy
);

    localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [REG_ADDR_W-1:0] ld_rd_q;
    logic                  ld_we_q;
    logic [2:0]            ld_f3_q;
    logic [2:0]            ld_lo_q;
    logic [XLEN-1:0]       src_data;
    logic [XLEN-1:0]       load_data;
    logic                  accept;
    logic                  timeout_hit;

    load_align #(.XLEN(XLEN)) u_load_align (
        .raw     (mem_rsp_data),
        .funct3  (ld_f3_q),
        .addr_lo (ld_lo_q),
        .data    (load_data)
    );

    assign accept      = in_valid && (state_q == ST_IDLE);
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_comb begin
        case (wb_sel)
            REG_WB_IMM_DAT: src_data = immediate;
            REG_WB_PC_NEXT: src_data = pc_next;
            default:        src_data = alu_result;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush outranks a response, which outranks the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && (wb_sel == REG_WB_MEM_DAT)) begin
                    state_d = ST_WAIT_MEM;
                end
            end
            ST_WAIT_MEM: begin
                if (flush || mem_rsp_valid || timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from state
    always_comb begin
        in_ready = (state_q == ST_IDLE);
        busy     = (state_q == ST_WAIT_MEM);
    end

    // Write port, fault pulse and timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            load_fault <= 1'b0;
            cnt_q      <= '0;
        end else begin
            rf_we      <= 1'b0;
            load_fault <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept && (wb_sel != REG_WB_MEM_DAT)) begin
                        rf_wdata <= src_data;
                        rf_waddr <= rd_addr;
                        rf_we    <= rd_we && (rd_addr != '0);
                    end else if (accept) begin
                        cnt_q <= '0;
                    end
                end
                ST_WAIT_MEM: begin
                    if (flush) begin
                        cnt_q <= '0;
                    end else if (mem_rsp_valid) begin
                        rf_wdata <= load_data;
                        rf_waddr <= ld_rd_q;
                        rf_we    <= ld_we_q && (ld_rd_q != '0);
                    end else if (timeout_hit) begin
                        load_fault <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Load context is plain data and needs no reset
    always_ff @(posedge clk) begin
        if (accept && (wb_sel == REG_WB_MEM_DAT)) begin
            ld_rd_q <= rd_addr;
            ld_we_q <= rd_we;
            ld_f3_q <= load_funct3;
            ld_lo_q <= load_addr_lo;
        end
    end

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage (XLEN=32, LOAD_TIMEOUT=8): directed
// scenarios plus randomized traffic against a transaction-level model.
module tb_write_back_stage;

    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam int TMO  = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      wb_sel = '0;
    logic [XLEN-1:0] alu_result = '0;
    logic [XLEN-1:0] immediate = '0;
    logic [XLEN-1:0] pc_next = '0;
    logic [RAW-1:0]  rd_addr = '0;
    logic            rd_we = 1'b0;
    logic [2:0]      load_funct3 = '0;
    logic [2:0]      load_addr_lo = '0;
    logic            flush = 1'b0;
    logic            mem_rsp_valid = 1'b0;
    logic [XLEN-1:0] mem_rsp_data = '0;
    logic            rf_we;
    logic [RAW-1:0]  rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            load_fault;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    write_back_stage #(.XLEN(XLEN), .REG_ADDR_W(RAW), .LOAD_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .wb_sel(wb_sel), .alu_result(alu_result), .immediate(immediate),
        .pc_next(pc_next), .rd_addr(rd_addr), .rd_we(rd_we),
        .load_funct3(load_funct3), .load_addr_lo(load_addr_lo), .flush(flush),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .load_fault(load_fault), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference load extraction from plain byte/halfword arithmetic
    function automatic logic [31:0] ref_align(input logic [2:0] f3, input logic [2:0] lo,
                                              input logic [31:0] raw);
        int unsigned b, h;
        b = (raw >> (8 * lo[1:0])) & 32'hFF;
        h = (raw >> (16 * lo[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b101:  return h;
            default: return raw;
        endcase
    endfunction

    // Entry and exit of every task is at a falling edge
    task automatic issue_reg(input logic [1:0] sel, input logic [RAW-1:0] rd,
                             input logic we, input logic [31:0] val);
        logic [31:0] srcs [4];
        check("in_ready_before_issue", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) srcs[i] = $urandom;
        srcs[sel] = val;
        alu_result = srcs[0];
        immediate  = srcs[1];
        pc_next    = srcs[3];
        wb_sel = sel; rd_addr = rd; rd_we = we; in_valid = 1'b1;
        @(negedge clk);
        check("reg_we", rf_we, we && (rd != 0));
        check("reg_fault", load_fault, 1'b0);
        if (we && (rd != 0)) begin
            check("reg_waddr", rf_waddr, rd);
            check("reg_wdata", rf_wdata, val);
        end
    endtask

    task automatic start_load(input logic [2:0] f3, input logic [2:0] lo,
                              input logic [RAW-1:0] rd, input logic we);
        check("in_ready_before_load", in_ready, 1'b1);
        wb_sel = 2'd2; load_funct3 = f3; load_addr_lo = lo;
        rd_addr = rd; rd_we = we; in_valid = 1'b1;
        alu_result = $urandom;
        @(negedge clk);
        in_valid = 1'b0;
        rd_addr = RAW'($urandom); rd_we = 1'(($urandom));
        check("load_accept_no_we", rf_we, 1'b0);
        check("load_busy", busy, 1'b1);
    endtask

    // rsp_at / flush_at are WAIT_MEM cycle numbers (1-based, 0 = never)
    task automatic do_load(input logic [2:0] f3, input logic [2:0] lo, input logic [31:0] raw,
                           input logic [RAW-1:0] rd, input logic we, input int rsp_at,
                           input int flush_at, input logic [31:0] exp);
        start_load(f3, lo, rd, we);
        for (int k = 1; k <= TMO; k++) begin
            check("wait_in_ready", in_ready, 1'b0);
            if (flush_at == k) begin
                flush = 1'b1;
                mem_rsp_valid = (rsp_at == k);
                mem_rsp_data = raw;
                @(negedge clk);
                flush = 1'b0; mem_rsp_valid = 1'b0;
                check("flush_no_we", rf_we, 1'b0);
                check("flush_no_fault", load_fault, 1'b0);
                check("flush_idle", in_ready, 1'b1);
                return;
            end else if (rsp_at == k) begin
                mem_rsp_valid = 1'b1; mem_rsp_data = raw;
                @(negedge clk);
                mem_rsp_valid = 1'b0; mem_rsp_data = $urandom;
                check("load_we", rf_we, we && (rd != 0));
                check("load_no_fault", load_fault, 1'b0);
                check("load_idle", in_ready, 1'b1);
                if (we && (rd != 0)) begin
                    check("load_waddr", rf_waddr, rd);
                    check("load_wdata", rf_wdata, exp);
                end
                return;
            end else begin
                @(negedge clk);
                check("wait_no_we", rf_we, 1'b0);
                if (k == TMO) begin
                    check("timeout_fault", load_fault, 1'b1);
                    check("timeout_idle", in_ready, 1'b1);
                end else begin
                    check("wait_no_fault", load_fault, 1'b0);
                end
            end
        end
    endtask

    initial begin
        logic [2:0]  f3, lo;
        logic [31:0] raw;
        int          rsp_at, flush_at;

        repeat (2) @(negedge clk);
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_fault", load_fault, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // back-to-back register writes, then rd=0
        issue_reg(2'd0, 5'd5, 1'b1, 32'h11);
        issue_reg(2'd1, 5'd6, 1'b1, 32'h22);
        issue_reg(2'd3, 5'd7, 1'b1, 32'h33);
        issue_reg(2'd0, 5'd0, 1'b1, 32'h44);
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_no_we", rf_we, 1'b0);

        do_load(3'b000, 3'd3, 32'h80FF_FFFF, 5'd9,  1'b1, 4, 0, 32'hFFFF_FF80);
        do_load(3'b100, 3'd3, 32'h80FF_FFFF, 5'd10, 1'b1, 4, 0, 32'h0000_0080);
        do_load(3'b101, 3'd2, 32'hABCD_1234, 5'd11, 1'b1, 2, 0, 32'h0000_ABCD);
        do_load(3'b001, 3'd2, 32'hABCD_1234, 5'd12, 1'b1, 1, 0, 32'hFFFF_ABCD);
        do_load(3'b010, 3'd4, 32'hDEAD_BEEF, 5'd13, 1'b1, 3, 0, 32'hDEAD_BEEF);

        // timeout, then response on the final count
        do_load(3'b010, 3'd0, 32'h1234_5678, 5'd14, 1'b1, 0, 0, 32'h0);
        do_load(3'b010, 3'd0, 32'h1234_5678, 5'd14, 1'b1, TMO, 0, 32'h1234_5678);

        // flush on 2nd wait cycle, ALU accepted right after, stale response later
        do_load(3'b010, 3'd0, 32'hCAFE_0001, 5'd15, 1'b1, 0, 2, 32'h0);
        issue_reg(2'd0, 5'd16, 1'b1, 32'h5555_AAAA);
        in_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_0001;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("stale_rsp_no_we", rf_we, 1'b0);
        check("stale_rsp_idle", in_ready, 1'b1);

        // reset mid-load
        start_load(3'b010, 3'd0, 5'd17, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_we", rf_we, 1'b0);
        check("midrst_waddr", rf_waddr, 0);
        check("midrst_wdata", rf_wdata, 0);
        check("midrst_fault", load_fault, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h7777_7777;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("post_rst_rsp_no_we", rf_we, 1'b0);
        check("post_rst_busy", busy, 1'b0);

        // randomized mix
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                logic [1:0] s;
                s = 2'($urandom_range(0, 2));
                if (s == 2'd2) s = 2'd3;
                issue_reg(s, RAW'($urandom), ($urandom_range(0, 3) != 0), $urandom);
                in_valid = 1'b0;
            end else begin
                f3 = 3'($urandom); lo = 3'($urandom); raw = $urandom;
                rsp_at   = $urandom_range(1, TMO + 2);
                flush_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, TMO) : 0;
                do_load(f3, lo, raw, RAW'($urandom), ($urandom_range(0, 3) != 0),
                        rsp_at, flush_at, ref_align(f3, lo, raw));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/write_back_stage.md
Name: write_back_stage

Overview:
- Registered write-back stage of the RV32/RV64 core, sitting between the memory stage and the register file.
- Selects the write-back source: ALU result, immediate, load data or PC+4.
- For loads, waits on a variable-latency data-memory response, then aligns and sign/zero-extends the data.
- Drives a single registered register-file write port, with a load-timeout fault and a pipeline flush.

Parameters:
- XLEN, 32: datapath width. Legal values are 32 and 64.
- REG_ADDR_W, 5: register address width.
- LOAD_TIMEOUT, 255: maximum number of WAIT_MEM cycles before a load fault is raised. Must be ≥ 1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  memory stage presents an instruction
- in_ready  out  1  stage can accept an instruction this cycle
- wb_sel  in  2  write-back source select
- alu_result  in  XLEN  ALU output
- immediate  in  XLEN  decoded immediate
- pc_next  in  XLEN  PC+4
- rd_addr  in  REG_ADDR_W  destination register
- rd_we  in  1  instruction writes rd
- load_funct3  in  3  load type
- load_addr_lo  in  3  low address bits of the load
- flush  in  1  kill the pending load
- mem_rsp_valid  in  1  data-memory response valid (single-cycle pulse)
- mem_rsp_data  in  XLEN  raw aligned memory word
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_ADDR_W  register-file write address
- rf_wdata  out  XLEN  register-file write data
- load_fault  out  1  one-cycle pulse when a load times out
- busy  out  1  high while in WAIT_MEM

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, load_fault=0, timeout counter=0.
- in_ready = (state==IDLE). It is combinational from state only.
- wb_sel encoding: 0=ALU, 1=IMM, 2=MEM, 3=PC_NEXT.

IDLE state:
- Acceptance occurs when in_valid & in_ready.
- wb_sel≠MEM: the next edge registers rf_wdata = the selected source and rf_waddr = rd_addr.
  - rf_we = rd_we & (rd_addr≠0).
  - Latency is 1 cycle; throughput is 1 instruction per cycle.
- wb_sel=MEM: the next edge latches rd_addr, rd_we, load_funct3 and load_addr_lo, clears the counter, and moves to WAIT_MEM. rf_we=0.
- No acceptance: rf_we=0 on the next edge.
- mem_rsp_valid is ignored in IDLE, including stale responses after a flush.

WAIT_MEM state (busy=1, in_ready=0):
- Priority order: rst > flush > mem_rsp_valid > timeout.
- flush: return to IDLE with no write. Any later response is dropped.
- mem_rsp_valid: the next edge registers rf_wdata = aligned(mem_rsp_data) and rf_we = rd_we & (rd_addr≠0), then returns to IDLE.
  - Load-use latency is 1 cycle after mem_rsp_valid.
- Otherwise the counter increments. When it reaches LOAD_TIMEOUT-1 and no response arrives:
  - load_fault pulses for 1 cycle on the next edge;
  - rf_we=0;
  - state returns to IDLE.
- A response that arrives on the same cycle as the final count wins: the write occurs and there is no fault.
- rf_we and load_fault are single-cycle pulses and are never high together.

Load alignment (shift by the byte offset, then extend to XLEN):
- funct3 000 LB: byte at offset addr_lo, sign-extended.
- funct3 100 LBU: byte at offset addr_lo, zero-extended.
- funct3 001 LH: halfword at addr_lo[2:1], sign-extended.
- funct3 101 LHU: halfword at addr_lo[2:1], zero-extended.
- funct3 010 LW: word at addr_lo[2], sign-extended.
- funct3 110 LWU: word at addr_lo[2], zero-extended. XLEN=64 only.
- funct3 011 LD: full word. XLEN=64 only.
- When XLEN=32, addr_lo[2] is ignored, LW passes the word through, and 011/110/111 behave as LW.
- When XLEN=64, 111 behaves as LD.
- Misaligned offsets are not checked; the low address bits are used as given.

Reset mid-operation: rst in WAIT_MEM returns to IDLE with no write and no fault.

Decomposition:
- Shared package: wb_sel encodings (REG_WB_ALU_OUT=0, REG_WB_IMM_DAT=1, REG_WB_MEM_DAT=2, REG_WB_PC_NEXT=3), load funct3 codes, and state encoding.
- One combinational sub-module, load_align (XLEN param; inputs raw data, funct3, addr_lo; output extended data).
- FSM, counter and output registers stay in write_back_stage.

Test Plan:
- Back-to-back ALU/IMM/PC instructions (wb_sel 0,1,3; rd 5,6,7; data 0x11, 0x22, 0x33) on consecutive cycles -> rf_we high for 3 consecutive cycles, each 1 cycle after acceptance, with matching address/data. An instruction with rd=0 produces rf_we=0.
- LB, addr_lo=3, mem_rsp_data=0x80FF_FFFF arriving 4 cycles after acceptance -> in_ready low for 4 cycles, then rf_wdata=0xFFFF_FF80 with rf_we one cycle after mem_rsp_valid. Repeated as LBU -> 0x0000_0080.
- LHU, addr_lo=2, data=0xABCD_1234 -> 0x0000_ABCD. LH with the same data -> 0xFFFF_ABCD.
- LOAD_TIMEOUT=8, no response -> after 8 WAIT_MEM cycles, load_fault pulses once, rf_we stays 0, in_ready returns to 1. Response on exactly the 8th cycle -> write, no fault.
- flush on the 2nd WAIT_MEM cycle, then mem_rsp_valid 2 cycles later -> no rf_we. A new ALU instruction accepted the cycle after the flush writes normally.
- rst asserted while in WAIT_MEM -> next cycle all outputs 0 and in_ready=1. A response after reset is ignored.
